// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared defaults and FSM state type for the image memory
package acc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 16;
    localparam int IMG_H_DEF  = 16;

    // Optional hex image preloaded into the frame memory by simulation flows; empty means none.
    localparam string IMG_INIT_FILE = "";

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } img_mem_state_e;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; the caller guarantees waddr_i is in range when we_i is high.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read: old contents on a same-cycle write, zero for addresses past the image.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= ({1'b0, raddr_i} < DEPTH_V) ? mem[raddr_i] : '0;
        end
    end

endmodule

// File: rtl/img_mem.sv
// rtl/img_mem.sv - frame buffer with raster stream load, direct write, clear and N read ports
module img_mem
    import acc_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  IMG_W  = IMG_W_DEF,
    parameter int  IMG_H  = IMG_H_DEF,
    parameter int  N_RD   = 2,
    localparam int DEPTH  = IMG_W * IMG_H,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [DATA_W-1:0]      s_data_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [N_RD-1:0]        rd_en_i,
    input  logic [N_RD*AW-1:0]     raddr_i,
    output logic [N_RD*DATA_W-1:0] rdata_o,
    output logic [N_RD-1:0]        rvalid_o,
    output logic                   busy_o,
    output logic                   frame_loaded_o,
    output logic                   addr_err_o
);

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    img_mem_state_e    state_q, state_d;
    logic [AW-1:0]     clr_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic              frame_loaded_q;
    logic              addr_err_q;
    logic [N_RD-1:0]   rvalid_q;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              stream_beat;
    logic              wr_oor;
    logic              enter_clr;
    logic [N_RD-1:0]   rd_oor;

    assign enter_clr      = (state_q == IDLE) && clr_i;
    assign busy_o         = (state_q == CLEAR);
    assign frame_loaded_o = frame_loaded_q;
    assign addr_err_o     = addr_err_q;
    assign rvalid_o       = rvalid_q;

    // Next state and the single shared write port: clear sweep, else direct write, else stream beat.
    always_comb begin
        state_d     = state_q;
        s_ready_o   = 1'b0;
        stream_beat = 1'b0;
        wr_oor      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = s_data_i;
        case (state_q)
            IDLE: begin
                s_ready_o = rst_ni && !we_i;
                if (clr_i) begin
                    state_d = CLEAR;
                end
                if (we_i) begin
                    if ({1'b0, waddr_i} < DEPTH_V) begin
                        mem_we    = 1'b1;
                        mem_waddr = waddr_i;
                        mem_wdata = wdata_i;
                    end else begin
                        wr_oor = 1'b1;
                    end
                end else if (s_valid_i) begin
                    stream_beat = 1'b1;
                    mem_we      = 1'b1;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (clr_ptr_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and the clear sweep address, which restarts from zero whenever idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= (state_q == CLEAR) ? clr_ptr_q + 1'b1 : '0;
        end
    end

    // Raster write pointer and frame-complete flag; a clear restarts the frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            frame_loaded_q <= 1'b0;
        end else if (enter_clr) begin
            wr_ptr_q       <= '0;
            frame_loaded_q <= 1'b0;
        end else if (stream_beat) begin
            frame_loaded_q <= (wr_ptr_q == LAST);
            wr_ptr_q       <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    // Sticky out-of-range flag, dropped only by reset or the start of a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_err_q <= 1'b0;
        end else if (enter_clr) begin
            addr_err_q <= 1'b0;
        end else if (wr_oor || (|rd_oor)) begin
            addr_err_q <= 1'b1;
        end
    end

    // Read valid follows the enable by one cycle on every port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rd_en_i;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        assign rd_oor[k] = rd_en_i[k] && ({1'b0, raddr_i[k*AW +: AW]} >= DEPTH_V);

        sdp_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_ram (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (mem_we),
            .waddr_i (mem_waddr),
            .wdata_i (mem_wdata),
            .re_i    (rd_en_i[k]),
            .raddr_i (raddr_i[k*AW +: AW]),
            .rdata_o (rdata_o[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_img_mem.sv
// tb/tb_img_mem.sv - self-checking bench for img_mem against a frame-level reference model
module tb_img_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16x16 instance
    logic        clr, s_valid, s_ready, we, busy, fl, err;
    logic [7:0]  s_data, wdata, waddr;
    logic [1:0]  rd_en, rvalid;
    logic [15:0] raddr, rdata;

    // 10x10 instance
    logic        clr1, s_valid1, s_ready1, we1, busy1, fl1, err1;
    logic [7:0]  s_data1, wdata1;
    logic [6:0]  waddr1;
    logic [1:0]  rd_en1, rvalid1;
    logic [13:0] raddr1;
    logic [15:0] rdata1;

    img_mem u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rd_en_i(rd_en), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
        .busy_o(busy), .frame_loaded_o(fl), .addr_err_o(err)
    );

    img_mem #(.IMG_W(10), .IMG_H(10)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr1),
        .s_valid_i(s_valid1), .s_ready_o(s_ready1), .s_data_i(s_data1),
        .we_i(we1), .waddr_i(waddr1), .wdata_i(wdata1),
        .rd_en_i(rd_en1), .raddr_i(raddr1), .rdata_o(rdata1), .rvalid_o(rvalid1),
        .busy_o(busy1), .frame_loaded_o(fl1), .addr_err_o(err1)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem_m [256];
    int         ptr_m;
    bit         fl_m;
    logic [7:0] exp_rd [2];
    logic [1:0] exp_rv;

    // One IDLE cycle on the 16x16 instance: model reads see old contents, then the write lands.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) begin
                exp_rd[k] = mem_m[raddr[k*8 +: 8]];
                exp_rv[k] = 1'b1;
            end else begin
                exp_rv[k] = 1'b0;
            end
        end
        if (we) begin
            mem_m[waddr] = wdata;
        end else if (s_valid) begin
            mem_m[ptr_m] = s_data;
            fl_m  = (ptr_m == 255);
            ptr_m = (ptr_m + 1) % 256;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 0; s_valid = 0; s_data = 0; we = 0; waddr = 0; wdata = 0; rd_en = 0; raddr = 0;
        clr1 = 0; s_valid1 = 0; s_data1 = 0; we1 = 0; waddr1 = 0; wdata1 = 0; rd_en1 = 0; raddr1 = 0;
        ptr_m = 0; fl_m = 0; exp_rd[0] = 0; exp_rd[1] = 0; exp_rv = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({busy, fl, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, fl, err}); end
        n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        n_chk++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
        rst_n = 1'b1;
        #1;
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_stream_load();
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            #1;
            n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready beat %0d: got %b expected 1", i, s_ready); end
            if (i == 255) begin
                n_chk++; if (fl !== 1'b0) begin n_fail++; $display("FAIL load_early_fl: got %b expected 0", fl); end
            end
            tick();
        end
        s_valid = 1'b0;
        n_chk++; if (fl !== 1'b1) begin n_fail++; $display("FAIL load_fl: got %b expected 1", fl); end
        rd_en = 2'b01; raddr[7:0] = 8'h80;
        tick();
        n_chk++; if (rdata[7:0] !== 8'h80) begin n_fail++; $display("FAIL load_read80: got %h expected 80", rdata[7:0]); end
        n_chk++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL load_rvalid: got %b expected 01", rvalid); end
        rd_en = 2'b00;
        tick();
        n_chk++; if (rvalid !== 2'b00 || rdata[7:0] !== 8'h80) begin
            n_fail++; $display("FAIL load_hold: got rvalid %b rdata %h expected 00 80", rvalid, rdata[7:0]);
        end
    endtask

    task automatic test_priority();
        s_valid = 1'b1; s_data = 8'h5A;
        we = 1'b1; waddr = 8'h10; wdata = 8'hAA;
        #1;
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready_low: got %b expected 0", s_ready); end
        tick();
        we = 1'b0;
        #1;
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_back: got %b expected 1", s_ready); end
        tick();
        s_valid = 1'b0;
        n_chk++; if (fl !== 1'b0) begin n_fail++; $display("FAIL prio_fl_cleared: got %b expected 0", fl); end
        rd_en = 2'b11; raddr = {8'h00, 8'h10};
        tick();
        rd_en = 2'b00;
        n_chk++; if (rdata !== {8'h5A, 8'hAA}) begin n_fail++; $display("FAIL prio_contents: got %h expected 5aaa", rdata); end
    endtask

    task automatic test_read_first();
        rd_en = 2'b11; raddr = {8'h05, 8'h05};
        we = 1'b1; waddr = 8'h05; wdata = 8'h11;
        tick();
        we = 1'b0;
        n_chk++; if (rdata !== 16'h0505) begin n_fail++; $display("FAIL rf_old: got %h expected 0505", rdata); end
        tick();
        rd_en = 2'b00;
        n_chk++; if (rdata !== 16'h1111) begin n_fail++; $display("FAIL rf_new: got %h expected 1111", rdata); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we      = ($urandom_range(0, 3) == 0);
            waddr   = 8'($urandom);
            wdata   = 8'($urandom);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            rd_en   = 2'($urandom);
            raddr   = 16'($urandom);
            #1;
            n_chk++; if (s_ready !== !we) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, s_ready, !we); end
            tick();
            n_chk++; if (rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", c, rvalid, exp_rv); end
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (rdata[k*8 +: 8] !== exp_rd[k]) begin
                    n_fail++; $display("FAIL rnd_rdata c%0d p%0d: got %h expected %h", c, k, rdata[k*8 +: 8], exp_rd[k]);
                end
            end
            n_chk++; if (fl !== fl_m) begin n_fail++; $display("FAIL rnd_fl c%0d: got %b expected %b", c, fl, fl_m); end
        end
        we = 0; s_valid = 0; rd_en = 0;
        tick();
    endtask

    task automatic test_clear();
        int busy_cnt;
        int ready_bad;
        s_valid = 1'b1;
        for (int g = 0; g < 256; g++) begin
            s_data = 8'($urandom);
            tick();
            if (ptr_m == 0) break;
        end
        s_valid = 1'b0;
        n_chk++; if (fl !== 1'b1) begin n_fail++; $display("FAIL clr_pre_fl: got %b expected 1", fl); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        busy_cnt = 0; ready_bad = 0;
        while (busy === 1'b1 && busy_cnt < 1000) begin
            if (s_ready !== 1'b0) ready_bad++;
            busy_cnt++;
            clr   = (busy_cnt == 100);
            we    = (busy_cnt == 250);
            waddr = 8'h20; wdata = 8'h99;
            @(posedge clk); #1;
        end
        clr = 0; we = 0;
        n_chk++; if (busy_cnt != 256) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d expected 256", busy_cnt); end
        n_chk++; if (ready_bad != 0) begin n_fail++; $display("FAIL clr_ready_low: got %0d high cycles expected 0", ready_bad); end
        n_chk++; if (fl !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL clr_flags: got fl %b err %b expected 0 0", fl, err); end
        for (int a = 0; a < 256; a++) mem_m[a] = 8'h00;
        ptr_m = 0; fl_m = 0; exp_rv = 0;
        for (int a = 0; a < 256; a += 2) begin
            rd_en = 2'b11; raddr = {8'(a + 1), 8'(a)};
            tick();
            n_chk++; if (rdata !== 16'h0000 || rvalid !== 2'b11) begin
                n_fail++; $display("FAIL clr_zero addr %0d: got %h/%b expected 0000/11", a, rdata, rvalid);
            end
        end
        rd_en = 2'b00;
        tick();
    endtask

    task automatic test_oor();
        int busy_cnt;
        n_chk++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL oor_err_init: got %b expected 0", err1); end
        we1 = 1'b1; waddr1 = 7'd120; wdata1 = 8'h77;
        @(posedge clk); #1;
        n_chk++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", err1); end
        waddr1 = 7'd99; wdata1 = 8'h3C;
        @(posedge clk); #1;
        we1 = 1'b0;
        rd_en1 = 2'b11; raddr1 = {7'd120, 7'd99};
        @(posedge clk); #1;
        rd_en1 = 2'b00;
        n_chk++; if (rdata1 !== {8'h00, 8'h3C}) begin n_fail++; $display("FAIL oor_rdata: got %h expected 003c", rdata1); end
        n_chk++; if (rvalid1 !== 2'b11) begin n_fail++; $display("FAIL oor_rvalid: got %b expected 11", rvalid1); end
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        busy_cnt = 0;
        while (busy1 === 1'b1 && busy_cnt < 500) begin
            busy_cnt++;
            @(posedge clk); #1;
        end
        n_chk++; if (busy_cnt != 100) begin n_fail++; $display("FAIL oor_clear_cycles: got %0d expected 100", busy_cnt); end
        n_chk++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL oor_err_cleared: got %b expected 0", err1); end
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; waddr = 8'd200; wdata = 8'h9D;
        tick();
        waddr = 8'd10; wdata = 8'h44;
        tick();
        we = 1'b0;
        rd_en = 2'b01; raddr[7:0] = 8'd200;
        tick();
        rd_en = 2'b00;
        n_chk++; if (rdata[7:0] !== 8'h9D) begin n_fail++; $display("FAIL mid_pre: got %h expected 9d", rdata[7:0]); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({busy, fl, err, rvalid, s_ready} !== 6'b0) begin
            n_fail++; $display("FAIL mid_rst_flags: got %b expected 000000", {busy, fl, err, rvalid, s_ready});
        end
        n_chk++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_rdata: got %h expected 0000", rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_idle: got busy %b ready %b expected 0 1", busy, s_ready);
        end
        for (int a = 0; a < 50; a++) mem_m[a] = 8'h00;
        ptr_m = 0; fl_m = 0; exp_rv = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        rd_en = 2'b11; raddr = {8'd10, 8'd200};
        tick();
        n_chk++; if (rdata !== {8'h00, 8'h9D}) begin n_fail++; $display("FAIL mid_contents: got %h expected 009d", rdata); end
        rd_en = 2'b00; s_valid = 1'b1; s_data = 8'hE1;
        tick();
        s_valid = 1'b0; rd_en = 2'b01; raddr[7:0] = 8'h00;
        tick();
        rd_en = 2'b00;
        n_chk++; if (rdata[7:0] !== 8'hE1) begin n_fail++; $display("FAIL mid_ptr_reset: got %h expected e1", rdata[7:0]); end
    endtask

    initial begin
        test_reset();
        test_stream_load();
        test_priority();
        test_read_first();
        test_random();
        test_clear();
        test_oor();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
